// File: rtl/csr_file_if.sv
// Bus between the pipeline and the machine-mode CSR file: ID-stage read, WB-stage write,
// trap/mret/wfi control and the resulting redirect and stall outputs.
interface csr_file_if;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        retire;
  logic        ext_irq;
  logic        mret;
  logic        wfi;
  logic [31:0] pc_next;
  logic        trap_take;
  logic [31:0] trap_pc;
  logic        mret_take;
  logic [31:0] mepc_out;
  logic        wfi_stall;

  modport master (
    output csr_raddr, csr_we, csr_waddr, csr_wdata, retire, ext_irq, mret, wfi, pc_next,
    input  csr_rdata, trap_take, trap_pc, mret_take, mepc_out, wfi_stall
  );

  modport slave (
    input  csr_raddr, csr_we, csr_waddr, csr_wdata, retire, ext_irq, mret, wfi, pc_next,
    output csr_rdata, trap_take, trap_pc, mret_take, mepc_out, wfi_stall
  );
endinterface

// File: rtl/csr_file.sv
// Minimal machine-mode CSR file: mstatus/mie/mtvec/mepc/mip, 64-bit cycle and instret
// counters, external-interrupt trap entry, mret return and a WFI sleep state.
module csr_file #(
  parameter logic [31:0] MTVEC_VAL = 32'h0001_0000
) (
  input  logic       clk,
  input  logic       rst,
  csr_file_if.slave  bus
);

  typedef enum logic {RUN, WFI_WAIT} state_e;

  state_e      state_q, state_d;
  logic        mstatMie_q, mstatMie_d;
  logic        mstatMpie_q, mstatMpie_d;
  logic [1:0]  mstatMpp_q, mstatMpp_d;
  logic        meie_q, meie_d;
  logic [31:0] mepc_q, mepc_d;
  logic        meip_q;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic irqPend, irqGo, trapTake, mretTake;
  logic unusedWdataBits;

  assign irqPend  = meip_q & meie_q;
  assign irqGo    = irqPend & mstatMie_q;
  assign mretTake = bus.mret & ~rst;
  assign trapTake = irqGo & ~bus.mret & ~rst;

  assign bus.trap_take = trapTake;
  assign bus.trap_pc   = MTVEC_VAL;
  assign bus.mret_take = mretTake;
  assign bus.mepc_out  = mepc_q;
  assign bus.wfi_stall = (state_q == WFI_WAIT);

  assign unusedWdataBits = ^{bus.csr_wdata[31:13], bus.csr_wdata[10:8], bus.csr_wdata[6:4],
                             bus.csr_wdata[2:0], bus.pc_next[1:0]};

  // Software write first; trap entry / mret then override the mstatus and mepc fields.
  always_comb begin
    mstatMie_d  = mstatMie_q;
    mstatMpie_d = mstatMpie_q;
    mstatMpp_d  = mstatMpp_q;
    meie_d      = meie_q;
    mepc_d      = mepc_q;
    mcycle_d    = mcycle_q + 64'd1;
    minstret_d  = minstret_q + {63'd0, bus.retire};

    if (bus.csr_we) begin
      case (bus.csr_waddr)
        12'h300: begin
          mstatMie_d  = bus.csr_wdata[3];
          mstatMpie_d = bus.csr_wdata[7];
          mstatMpp_d  = bus.csr_wdata[12:11];
        end
        12'h304: meie_d = bus.csr_wdata[11];
        12'h341: mepc_d = {bus.csr_wdata[31:2], 2'b00};
        default: ;
      endcase
    end

    if (mretTake) begin
      mstatMie_d  = mstatMpie_q;
      mstatMpie_d = 1'b1;
      mstatMpp_d  = 2'b11;
    end else if (trapTake) begin
      mepc_d      = {bus.pc_next[31:2], 2'b00};
      mstatMpie_d = mstatMie_q;
      mstatMie_d  = 1'b0;
      mstatMpp_d  = 2'b11;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (bus.wfi && !irqPend) state_d = WFI_WAIT;
      WFI_WAIT: if (irqPend) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      mstatMie_q  <= 1'b0;
      mstatMpie_q <= 1'b0;
      mstatMpp_q  <= 2'b00;
      meie_q      <= 1'b0;
      mepc_q      <= 32'd0;
      meip_q      <= 1'b0;
      mcycle_q    <= 64'd0;
      minstret_q  <= 64'd0;
    end else begin
      state_q     <= state_d;
      mstatMie_q  <= mstatMie_d;
      mstatMpie_q <= mstatMpie_d;
      mstatMpp_q  <= mstatMpp_d;
      meie_q      <= meie_d;
      mepc_q      <= mepc_d;
      meip_q      <= bus.ext_irq;
      mcycle_q    <= mcycle_d;
      minstret_q  <= minstret_d;
    end
  end

  // Reads come straight from the registers, so a write shows up only on the following cycle.
  always_comb begin
    bus.csr_rdata = 32'd0;
    case (bus.csr_raddr)
      12'h300: bus.csr_rdata = {19'd0, mstatMpp_q, 3'd0, mstatMpie_q, 3'd0, mstatMie_q, 3'd0};
      12'h304: bus.csr_rdata = {20'd0, meie_q, 11'd0};
      12'h305: bus.csr_rdata = MTVEC_VAL;
      12'h341: bus.csr_rdata = mepc_q;
      12'h344: bus.csr_rdata = {20'd0, meip_q, 11'd0};
      12'hB00, 12'hC00: bus.csr_rdata = mcycle_q[31:0];
      12'hB80, 12'hC80: bus.csr_rdata = mcycle_q[63:32];
      12'hB02, 12'hC02: bus.csr_rdata = minstret_q[31:0];
      12'hB82, 12'hC82: bus.csr_rdata = minstret_q[63:32];
      default: bus.csr_rdata = 32'd0;
    endcase
  end

endmodule
